// File: rtl/robo_pkg.sv
// rtl/robo_pkg.sv - shared heading, command code and trace entry layout definitions
package robo_pkg;

  typedef enum logic [1:0] {
    HEAD_N = 2'd0,
    HEAD_E = 2'd1,
    HEAD_S = 2'd2,
    HEAD_W = 2'd3
  } heading_e;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_ADV  = 2'd1;
  localparam logic [1:0] CMD_TURN = 2'd2;
  localparam logic [1:0] CMD_REM  = 2'd3;

  localparam int TR_CMD_W  = 2;
  localparam int TR_HEAD_W = 2;

  // Trace entry is {cmd, heading, pos_x, pos_y}, pos_y in the low bits.
  function automatic int tr_width(input int pos_w);
    return TR_CMD_W + TR_HEAD_W + 2 * pos_w;
  endfunction

  function automatic int tr_y_lsb(input int pos_w);
    return 0 * pos_w;
  endfunction

  function automatic int tr_x_lsb(input int pos_w);
    return pos_w;
  endfunction

  function automatic int tr_head_lsb(input int pos_w);
    return 2 * pos_w;
  endfunction

  function automatic int tr_cmd_lsb(input int pos_w);
    return 2 * pos_w + TR_HEAD_W;
  endfunction

endpackage

// File: rtl/odo_trace_fifo.sv
// rtl/odo_trace_fifo.sv - synchronous trace FIFO with sticky overflow
// Read side is registered state only; a write is never bypassed to the output.
module odo_trace_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign pop   = !empty && rd_ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push  = wr_en && (!full || pop);

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/robo_odometer.sv
// rtl/robo_odometer.sv - dead-reckoning odometer with command checking
// Optional trace FIFO enabled by defining ODO_TRACE_EN.
module robo_odometer
  import robo_pkg::*;
#(
  parameter int POS_W      = 4,
  parameter int CNT_W      = 16,
  parameter int X_INIT     = 0,
  parameter int Y_INIT     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 avancar,
  input  logic                 girar,
  input  logic                 remover,
  input  logic                 head,
  output logic [POS_W-1:0]     pos_x,
  output logic [POS_W-1:0]     pos_y,
  output logic [1:0]           heading,
  output logic [CNT_W-1:0]     step_count,
  output logic [CNT_W-1:0]     turn_count,
  output logic [CNT_W-1:0]     remove_count,
  output logic                 cmd_error,
  output logic                 collision,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [4+2*POS_W-1:0] trace_data,
  output logic                 trace_overflow
);

  localparam int TR_W   = tr_width(POS_W);
  localparam int Y_LSB  = tr_y_lsb(POS_W);
  localparam int X_LSB  = tr_x_lsb(POS_W);
  localparam int H_LSB  = tr_head_lsb(POS_W);
  localparam int C_LSB  = tr_cmd_lsb(POS_W);

  heading_e         heading_q;
  heading_e         heading_nxt;
  logic [POS_W-1:0] x_nxt;
  logic [POS_W-1:0] y_nxt;
  logic [1:0]       n_cmd;
  logic             legal;
  logic             illegal;
  logic             do_adv;
  logic             do_move;
  logic             do_turn;
  logic             do_rem;
  logic [1:0]       cmd_code;
  logic [TR_W-1:0]  entry;
  logic             entry_we;

  assign heading = heading_q;

  always_comb begin
    n_cmd   = 2'(avancar) + 2'(girar) + 2'(remover);
    legal   = (n_cmd == 2'd1);
    illegal = (n_cmd >= 2'd2);
    do_adv  = legal && avancar;
    do_move = do_adv && !head;
    do_turn = legal && girar;
    do_rem  = legal && remover;

    heading_nxt = heading_q;
    x_nxt       = pos_x;
    y_nxt       = pos_y;
    cmd_code    = CMD_NONE;

    if (do_turn) begin
      heading_nxt = heading_e'(heading_q + 2'd1);
      cmd_code    = CMD_TURN;
    end
    if (do_adv) begin
      cmd_code = CMD_ADV;
    end
    if (do_rem) begin
      cmd_code = CMD_REM;
    end
    if (do_move) begin
      case (heading_q)
        HEAD_N:  y_nxt = pos_y + POS_W'(1);
        HEAD_E:  x_nxt = pos_x + POS_W'(1);
        HEAD_S:  y_nxt = pos_y - POS_W'(1);
        default: x_nxt = pos_x - POS_W'(1);
      endcase
    end

    // Trace carries the post-update state, matching what the outputs show next cycle.
    entry                         = '0;
    entry[C_LSB +: TR_CMD_W]      = cmd_code;
    entry[H_LSB +: TR_HEAD_W]     = heading_nxt;
    entry[X_LSB +: POS_W]         = x_nxt;
    entry[Y_LSB +: POS_W]         = y_nxt;
    entry_we                      = legal;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_x        <= POS_W'(X_INIT);
      pos_y        <= POS_W'(Y_INIT);
      heading_q    <= HEAD_N;
      step_count   <= '0;
      turn_count   <= '0;
      remove_count <= '0;
      cmd_error    <= 1'b0;
      collision    <= 1'b0;
    end else begin
      pos_x     <= x_nxt;
      pos_y     <= y_nxt;
      heading_q <= heading_nxt;
      if (do_move && step_count != '1) begin
        step_count <= step_count + CNT_W'(1);
      end
      if (do_turn && turn_count != '1) begin
        turn_count <= turn_count + CNT_W'(1);
      end
      if (do_rem && remove_count != '1) begin
        remove_count <= remove_count + CNT_W'(1);
      end
      if (illegal) begin
        cmd_error <= 1'b1;
      end
      if (do_adv && head) begin
        collision <= 1'b1;
      end
    end
  end

`ifdef ODO_TRACE_EN
  odo_trace_fifo #(
    .WIDTH (TR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_trace_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (entry_we),
    .wr_data  (entry),
    .rd_ready (trace_ready),
    .rd_valid (trace_valid),
    .rd_data  (trace_data),
    .overflow (trace_overflow)
  );
`else
  logic unused_trace;
  assign unused_trace   = ^{trace_ready, entry, entry_we, FIFO_DEPTH[0]};
  assign trace_valid    = 1'b0;
  assign trace_data     = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_robo_odometer.sv
// tb/tb_robo_odometer.sv - directed self-checking bench for robo_odometer
// Trace expectations collapse to zero when ODO_TRACE_EN is not defined.
module tb_robo_odometer;

  localparam int POS_W = 4;
  localparam int CNT_W = 4;
  localparam int TW    = 4 + 2 * POS_W;
`ifdef ODO_TRACE_EN
  localparam logic TR = 1'b1;
`else
  localparam logic TR = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             avancar = 1'b0;
  logic             girar = 1'b0;
  logic             remover = 1'b0;
  logic             head = 1'b0;
  logic             trace_ready = 1'b0;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [1:0]       heading;
  logic [CNT_W-1:0] step_count;
  logic [CNT_W-1:0] turn_count;
  logic [CNT_W-1:0] remove_count;
  logic             cmd_error;
  logic             collision;
  logic             trace_valid;
  logic [TW-1:0]    trace_data;
  logic             trace_overflow;

  int n_cmp = 0;
  int n_err = 0;

  robo_odometer #(
    .POS_W      (POS_W),
    .CNT_W      (CNT_W),
    .X_INIT     (0),
    .Y_INIT     (0),
    .FIFO_DEPTH (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .avancar        (avancar),
    .girar          (girar),
    .remover        (remover),
    .head           (head),
    .pos_x          (pos_x),
    .pos_y          (pos_y),
    .heading        (heading),
    .step_count     (step_count),
    .turn_count     (turn_count),
    .remove_count   (remove_count),
    .cmd_error      (cmd_error),
    .collision      (collision),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] tv(input logic [TW-1:0] e);
    return TR ? e : '0;
  endfunction

  task automatic drive(input logic a, input logic g, input logic r, input logic h);
    avancar = a; girar = g; remover = r; head = h;
    @(posedge clock); #1;
    avancar = 1'b0; girar = 1'b0; remover = 1'b0; head = 1'b0;
  endtask

  task automatic turn();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic adv(input logic h);
    drive(1'b1, 1'b0, 1'b0, h);
  endtask

  task automatic check_state(input string tag, input logic [3:0] x, input logic [3:0] y,
                             input logic [1:0] hd, input logic [3:0] st,
                             input logic [3:0] tn, input logic [3:0] rm);
    check_eq({tag, ".pos_x"}, 32'(pos_x), 32'(x));
    check_eq({tag, ".pos_y"}, 32'(pos_y), 32'(y));
    check_eq({tag, ".heading"}, 32'(heading), 32'(hd));
    check_eq({tag, ".step"}, 32'(step_count), 32'(st));
    check_eq({tag, ".turn"}, 32'(turn_count), 32'(tn));
    check_eq({tag, ".remove"}, 32'(remove_count), 32'(rm));
  endtask

  task automatic pop_check(input string tag, input logic [TW-1:0] exp);
    check_eq({tag, ".valid"}, 32'(trace_valid), 32'(TR));
    check_eq({tag, ".data"}, 32'(trace_data), 32'(tv(exp)));
    trace_ready = 1'b1;
    @(posedge clock); #1;
    trace_ready = 1'b0;
  endtask

  logic [1:0]    seq_cmd [10] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3};
  logic [TW-1:0] seq_exp [8]  = '{12'hB00, 12'h7F0, 12'h8F0, 12'h4F1,
                                  12'h9F1, 12'h501, 12'hD01, 12'hA01};
  logic [TW-1:0] turn_exp [4] = '{12'h900, 12'hA00, 12'hB00, 12'h800};

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_state("rst", 4'd0, 4'd0, 2'd0, 4'd0, 4'd0, 4'd0);
    check_eq("rst.cmd_error", 32'(cmd_error), 32'd0);
    check_eq("rst.collision", 32'(collision), 32'd0);
    check_eq("rst.tr_valid", 32'(trace_valid), 32'd0);
    check_eq("rst.tr_data", 32'(trace_data), 32'd0);
    check_eq("rst.tr_ovf", 32'(trace_overflow), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 1; i <= 4; i++) begin
      turn();
      check_eq("turn.heading", 32'(heading), 32'(i % 4));
    end
    check_eq("turn.count", 32'(turn_count), 32'd4);
    for (int i = 0; i < 4; i++) pop_check("turn.trace", turn_exp[i]);
    check_eq("turn.drained", 32'(trace_valid), 32'd0);

    trace_ready = 1'b1;
    turn(); turn(); turn();
    adv(1'b0);
    check_state("west", 4'd15, 4'd0, 2'd3, 4'd1, 4'd7, 4'd0);
    turn(); turn();
    adv(1'b0);
    check_state("east_wrap", 4'd0, 4'd0, 2'd1, 4'd2, 4'd9, 4'd0);
    turn(); turn(); turn();
    adv(1'b0);
    check_state("north", 4'd0, 4'd1, 2'd0, 4'd3, 4'd12, 4'd0);
    turn(); turn();
    adv(1'b0);
    check_state("south", 4'd0, 4'd0, 2'd2, 4'd4, 4'd14, 4'd0);
    @(posedge clock); #1;
    check_eq("stream.drained", 32'(trace_valid), 32'd0);
    trace_ready = 1'b0;

    adv(1'b1);
    check_state("coll", 4'd0, 4'd0, 2'd2, 4'd4, 4'd14, 4'd0);
    check_eq("coll.flag", 32'(collision), 32'd1);
    check_eq("coll.cmd_error", 32'(cmd_error), 32'd0);
    check_eq("coll.tr_valid", 32'(trace_valid), 32'(TR));
    check_eq("coll.tr_data", 32'(trace_data), 32'(tv(12'h600)));

    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("illegal.cmd_error", 32'(cmd_error), 32'd1);
    check_state("illegal", 4'd0, 4'd0, 2'd2, 4'd4, 4'd14, 4'd0);
    pop_check("illegal.head", 12'h600);
    check_eq("illegal.no_entry", 32'(trace_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(seq_cmd[i] == 2'd1, seq_cmd[i] == 2'd2, seq_cmd[i] == 2'd3, 1'b0);
    end
    check_state("ovf", 4'd0, 4'd0, 2'd2, 4'd8, 4'd15, 4'd2);
    check_eq("ovf.flag", 32'(trace_overflow), 32'(TR));
    check_eq("ovf.sticky_coll", 32'(collision), 32'd1);
    check_eq("ovf.sticky_err", 32'(cmd_error), 32'd1);
    for (int i = 0; i < 5; i++) pop_check("ovf.drain", seq_exp[i]);
    check_eq("ovf.left_valid", 32'(trace_valid), 32'(TR));
    check_eq("ovf.left_data", 32'(trace_data), 32'(tv(seq_exp[5])));

    trace_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_state("async_rst", 4'd0, 4'd0, 2'd0, 4'd0, 4'd0, 4'd0);
    check_eq("async_rst.cmd_error", 32'(cmd_error), 32'd0);
    check_eq("async_rst.collision", 32'(collision), 32'd0);
    check_eq("async_rst.tr_valid", 32'(trace_valid), 32'd0);
    check_eq("async_rst.tr_data", 32'(trace_data), 32'd0);
    check_eq("async_rst.tr_ovf", 32'(trace_overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
